// File: rtl/hazard_scoreboard_pkg.sv
// Shared codes, select encodings, stage entry layouts and code-to-cycle helpers
// for the pipeline hazard scoreboard.
package hazard_scoreboard_pkg;

  localparam int REG_AW = 5;
  localparam int CNT_W  = 2;

  localparam logic [2:0] TUSE_NONE = 3'd0;
  localparam logic [2:0] TUSE_D    = 3'd1;
  localparam logic [2:0] TUSE_E    = 3'd2;
  localparam logic [2:0] TUSE_M    = 3'd3;

  localparam logic [2:0] TNEW_PC8  = 3'd0;
  localparam logic [2:0] TNEW_IMM  = 3'd1;
  localparam logic [2:0] TNEW_ALU  = 3'd2;
  localparam logic [2:0] TNEW_DM   = 3'd3;

  // One select encoding shared by every mux; E-stage and M-stage muxes never see FWD_E.
  localparam logic [1:0] FWD_NONE  = 2'd0;
  localparam logic [1:0] FWD_M     = 2'd1;
  localparam logic [1:0] FWD_W     = 2'd2;
  localparam logic [1:0] FWD_E     = 2'd3;

  typedef struct packed {
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] wreg;
    logic [CNT_W-1:0]  cnt;
  } e_entry_t;

  typedef struct packed {
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] wreg;
    logic [CNT_W-1:0]  cnt;
  } m_entry_t;

  typedef struct packed {
    logic [REG_AW-1:0] wreg;
    logic [CNT_W-1:0]  cnt;
  } w_entry_t;

  function automatic logic [CNT_W-1:0] tuse_cycles(input logic [2:0] code);
    case (code)
      TUSE_E:  return CNT_W'(1);
      TUSE_M:  return CNT_W'(2);
      default: return '0;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] tnew_cycles(input logic [2:0] code);
    case (code)
      TNEW_ALU: return CNT_W'(1);
      TNEW_DM:  return CNT_W'(2);
      default:  return '0;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] cnt_dec(input logic [CNT_W-1:0] c);
    return (c == '0) ? '0 : c - CNT_W'(1);
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// D-stage decode fields into the scoreboard and stall/forward selects out of it.
// No handshake: every signal is valid each cycle; outputs are combinational.
interface hazard_scoreboard_if;
  import hazard_scoreboard_pkg::*;

  logic [REG_AW-1:0] d_rs;
  logic [REG_AW-1:0] d_rt;
  logic [REG_AW-1:0] d_wreg;
  logic [2:0]        d_tuse_rs;
  logic [2:0]        d_tuse_rt;
  logic [2:0]        d_tnew;
  logic              stall;
  logic [1:0]        fwd_d_rs;
  logic [1:0]        fwd_d_rt;
  logic [1:0]        fwd_e_rs;
  logic [1:0]        fwd_e_rt;
  logic              fwd_m_rt;

  modport master (
    output d_rs, d_rt, d_wreg, d_tuse_rs, d_tuse_rt, d_tnew,
    input  stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt
  );

  modport slave (
    input  d_rs, d_rt, d_wreg, d_tuse_rs, d_tuse_rt, d_tnew,
    output stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt
  );
endinterface

// File: rtl/hazard_scoreboard_match.sv
// Resolves one source operand against the E/M/W writer entries: the nearest
// match decides both the stall request and the forward select.
module hazard_match
  import hazard_scoreboard_pkg::*;
(
  input  logic [REG_AW-1:0] r,
  input  logic              check,
  input  logic [CNT_W-1:0]  tuse,
  input  logic [REG_AW-1:0] e_wreg,
  input  logic [CNT_W-1:0]  e_cnt,
  input  logic [REG_AW-1:0] m_wreg,
  input  logic [CNT_W-1:0]  m_cnt,
  input  logic [REG_AW-1:0] w_wreg,
  input  logic [CNT_W-1:0]  w_cnt,
  output logic              stall_req,
  output logic [1:0]        fwd_sel
);

  logic live;
  logic hit_e, hit_m, hit_w;

  // A stage tied to wreg=0 by the parent is effectively absent.
  assign live  = check && (r != '0);
  assign hit_e = live && (e_wreg == r);
  assign hit_m = live && (m_wreg == r);
  assign hit_w = live && (w_wreg == r);

  always_comb begin
    stall_req = 1'b0;
    fwd_sel   = FWD_NONE;
    if (hit_e) begin
      stall_req = (e_cnt > tuse);
      if (e_cnt == '0) fwd_sel = FWD_E;
    end else if (hit_m) begin
      stall_req = (m_cnt > tuse);
      if (m_cnt == '0) fwd_sel = FWD_M;
    end else if (hit_w) begin
      stall_req = (w_cnt > tuse);
      if (w_cnt == '0) fwd_sel = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Writer scoreboard for the E/M/W stages: shadow entries with Tnew countdowns
// drive the D-freeze stall and the D/E/M forward-mux selects.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  hazard_scoreboard_if.slave bus
);

  e_entry_t e_q;
  m_entry_t m_q;
  w_entry_t w_q;

  logic [4:0] req;
  logic [1:0] sel_d_rs, sel_d_rt, sel_e_rs, sel_e_rt, sel_m_rt;
  logic       stall;

  // Operands already past D are tied to the largest Tuse, so they can never stall.
  localparam logic [CNT_W-1:0] TUSE_MAX = '1;
  localparam logic [REG_AW-1:0] NO_REG  = '0;

  hazard_match u_d_rs (
    .r(bus.d_rs), .check(bus.d_tuse_rs != TUSE_NONE), .tuse(tuse_cycles(bus.d_tuse_rs)),
    .e_wreg(e_q.wreg), .e_cnt(e_q.cnt), .m_wreg(m_q.wreg), .m_cnt(m_q.cnt),
    .w_wreg(w_q.wreg), .w_cnt(w_q.cnt), .stall_req(req[0]), .fwd_sel(sel_d_rs)
  );

  hazard_match u_d_rt (
    .r(bus.d_rt), .check(bus.d_tuse_rt != TUSE_NONE), .tuse(tuse_cycles(bus.d_tuse_rt)),
    .e_wreg(e_q.wreg), .e_cnt(e_q.cnt), .m_wreg(m_q.wreg), .m_cnt(m_q.cnt),
    .w_wreg(w_q.wreg), .w_cnt(w_q.cnt), .stall_req(req[1]), .fwd_sel(sel_d_rt)
  );

  hazard_match u_e_rs (
    .r(e_q.rs), .check(1'b1), .tuse(TUSE_MAX),
    .e_wreg(NO_REG), .e_cnt('0), .m_wreg(m_q.wreg), .m_cnt(m_q.cnt),
    .w_wreg(w_q.wreg), .w_cnt(w_q.cnt), .stall_req(req[2]), .fwd_sel(sel_e_rs)
  );

  hazard_match u_e_rt (
    .r(e_q.rt), .check(1'b1), .tuse(TUSE_MAX),
    .e_wreg(NO_REG), .e_cnt('0), .m_wreg(m_q.wreg), .m_cnt(m_q.cnt),
    .w_wreg(w_q.wreg), .w_cnt(w_q.cnt), .stall_req(req[3]), .fwd_sel(sel_e_rt)
  );

  hazard_match u_m_rt (
    .r(m_q.rt), .check(1'b1), .tuse(TUSE_MAX),
    .e_wreg(NO_REG), .e_cnt('0), .m_wreg(NO_REG), .m_cnt('0),
    .w_wreg(w_q.wreg), .w_cnt(w_q.cnt), .stall_req(req[4]), .fwd_sel(sel_m_rt)
  );

  assign stall        = |req;
  assign bus.stall    = stall;
  assign bus.fwd_d_rs = sel_d_rs;
  assign bus.fwd_d_rt = sel_d_rt;
  assign bus.fwd_e_rs = sel_e_rs;
  assign bus.fwd_e_rt = sel_e_rt;
  assign bus.fwd_m_rt = (sel_m_rt == FWD_W);

  // A stalled D slot enters E as an all-zero bubble; M and W keep draining.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_q <= '0;
      m_q <= '0;
      w_q <= '0;
    end else begin
      if (stall) begin
        e_q <= '0;
      end else begin
        e_q <= '{rs: bus.d_rs, rt: bus.d_rt, wreg: bus.d_wreg, cnt: tnew_cycles(bus.d_tnew)};
      end
      m_q <= '{rt: e_q.rt, wreg: e_q.wreg, cnt: cnt_dec(e_q.cnt)};
      w_q <= '{wreg: m_q.wreg, cnt: cnt_dec(m_q.cnt)};
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Instruction-sequence bench for hazard_scoreboard: each scenario drives D-stage
// decode fields cycle by cycle and checks stall/forward selects against expectations.
module tb_hazard_scoreboard;
  import hazard_scoreboard_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_scoreboard_if hif();

  hazard_scoreboard dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (hif)
  );

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] wreg;
    logic [2:0] tu_rs;
    logic [2:0] tu_rt;
    logic [2:0] tnew;
  } instr_t;

  logic [9:0] exp_q[$];
  int total = 0;
  int bad = 0;

  function automatic instr_t mk(input int rs, input int rt, input int wreg,
                                input int tu_rs, input int tu_rt, input int tnew);
    instr_t i;
    i.rs = 5'(rs); i.rt = 5'(rt); i.wreg = 5'(wreg);
    i.tu_rs = 3'(tu_rs); i.tu_rt = 3'(tu_rt); i.tnew = 3'(tnew);
    return i;
  endfunction

  // {stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt}
  function automatic logic [9:0] ex(input int s, input int drs, input int drt,
                                    input int ers, input int ert, input int mrt);
    return {1'(s), 2'(drs), 2'(drt), 2'(ers), 2'(ert), 1'(mrt)};
  endfunction

  function automatic logic [9:0] outs();
    return {hif.stall, hif.fwd_d_rs, hif.fwd_d_rt, hif.fwd_e_rs, hif.fwd_e_rt, hif.fwd_m_rt};
  endfunction

  instr_t nop, lw1, addu2, beq1, addu4, beq44, jal31, jr31, lui5, sw5;
  instr_t addu0, beq00, lui6, beq6, lw7, lui7, beq7;

  task automatic set_d(input instr_t i);
    hif.d_rs = i.rs; hif.d_rt = i.rt; hif.d_wreg = i.wreg;
    hif.d_tuse_rs = i.tu_rs; hif.d_tuse_rt = i.tu_rt; hif.d_tnew = i.tnew;
  endtask

  task automatic drive(input instr_t i, input logic [9:0] e);
    set_d(i);
    exp_q.push_back(e);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic flush();
    for (int k = 0; k < 3; k++) begin
      set_d(nop);
      next_cycle();
    end
  endtask

  task automatic test_reset();
    logic [9:0] got, e;
    drive(lw1, ex(0,0,0,0,0,0));
    #2 got = outs(); e = exp_q.pop_front(); total++;
    if (got !== e) begin bad++; $display("FAIL reset_idle got=%h exp=%h", got, e); end
    next_cycle();
    drive(addu2, ex(0,0,0,0,0,0));
    #2 got = outs(); e = exp_q.pop_front(); total++;
    if (got !== e) begin bad++; $display("FAIL reset_held got=%h exp=%h", got, e); end
    next_cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_lw_use();
    instr_t p[4];
    logic [9:0] v[4];
    logic [9:0] got, e;
    p = '{lw1, addu2, addu2, nop};
    v = '{ex(0,0,0,0,0,0), ex(1,0,0,0,0,0), ex(0,0,0,0,0,0), ex(0,0,0,2,0,0)};
    flush();
    for (int k = 0; k < 4; k++) begin
      drive(p[k], v[k]);
      #2 got = outs(); e = exp_q.pop_front(); total++;
      if (got !== e) begin bad++; $display("FAIL lw_use[%0d] got=%h exp=%h", k, got, e); end
      next_cycle();
    end
  endtask

  task automatic test_lw_branch();
    instr_t p[5];
    logic [9:0] v[5];
    logic [9:0] got, e;
    p = '{lw1, beq1, beq1, beq1, nop};
    v = '{ex(0,0,0,0,0,0), ex(1,0,0,0,0,0), ex(1,0,0,0,0,0), ex(0,2,0,0,0,0), ex(0,0,0,0,0,0)};
    flush();
    for (int k = 0; k < 5; k++) begin
      drive(p[k], v[k]);
      #2 got = outs(); e = exp_q.pop_front(); total++;
      if (got !== e) begin bad++; $display("FAIL lw_branch[%0d] got=%h exp=%h", k, got, e); end
      next_cycle();
    end
  endtask

  task automatic test_alu_branch();
    instr_t p[4];
    logic [9:0] v[4];
    logic [9:0] got, e;
    p = '{addu4, beq44, beq44, nop};
    v = '{ex(0,0,0,0,0,0), ex(1,0,0,0,0,0), ex(0,1,1,0,0,0), ex(0,0,0,2,2,0)};
    flush();
    for (int k = 0; k < 4; k++) begin
      drive(p[k], v[k]);
      #2 got = outs(); e = exp_q.pop_front(); total++;
      if (got !== e) begin bad++; $display("FAIL alu_branch[%0d] got=%h exp=%h", k, got, e); end
      next_cycle();
    end
  endtask

  task automatic test_no_stall_fwd();
    instr_t p[7];
    logic [9:0] v[7];
    logic [9:0] got, e;
    p = '{jal31, jr31, nop, lui5, sw5, nop, nop};
    v = '{ex(0,0,0,0,0,0), ex(0,3,0,0,0,0), ex(0,0,0,1,0,0),
          ex(0,0,0,0,0,0), ex(0,0,3,0,0,0), ex(0,0,0,0,1,0), ex(0,0,0,0,0,1)};
    flush();
    for (int k = 0; k < 7; k++) begin
      if (k == 3) flush();
      drive(p[k], v[k]);
      #2 got = outs(); e = exp_q.pop_front(); total++;
      if (got !== e) begin bad++; $display("FAIL no_stall_fwd[%0d] got=%h exp=%h", k, got, e); end
      next_cycle();
    end
  endtask

  task automatic test_zero_and_priority();
    instr_t p[8];
    logic [9:0] v[8];
    logic [9:0] got, e;
    p = '{addu0, beq00, nop, lui6, lui6, beq6, nop, nop};
    v = '{ex(0,0,0,0,0,0), ex(0,0,0,0,0,0), ex(0,0,0,0,0,0),
          ex(0,0,0,0,0,0), ex(0,0,0,0,0,0), ex(0,3,0,0,1,0), ex(0,0,0,1,0,1), ex(0,0,0,0,0,0)};
    flush();
    for (int k = 0; k < 8; k++) begin
      if (k == 3) flush();
      drive(p[k], v[k]);
      #2 got = outs(); e = exp_q.pop_front(); total++;
      if (got !== e) begin bad++; $display("FAIL zero_prio[%0d] got=%h exp=%h", k, got, e); end
      next_cycle();
    end
  endtask

  task automatic test_nearest_only();
    instr_t p[4];
    logic [9:0] v[4];
    logic [9:0] got, e;
    p = '{lw7, lui7, beq7, nop};
    v = '{ex(0,0,0,0,0,0), ex(0,0,0,0,0,0), ex(0,3,0,0,0,0), ex(0,0,0,1,0,1)};
    flush();
    for (int k = 0; k < 4; k++) begin
      drive(p[k], v[k]);
      #2 got = outs(); e = exp_q.pop_front(); total++;
      if (got !== e) begin bad++; $display("FAIL nearest[%0d] got=%h exp=%h", k, got, e); end
      next_cycle();
    end
  endtask

  task automatic test_reset_mid_stall();
    instr_t p[3];
    logic [9:0] v[3];
    logic [9:0] got, e;
    flush();
    drive(lw1, ex(0,0,0,0,0,0));
    #2 got = outs(); e = exp_q.pop_front(); total++;
    if (got !== e) begin bad++; $display("FAIL rst_stall_lw got=%h exp=%h", got, e); end
    next_cycle();
    drive(addu2, ex(1,0,0,0,0,0));
    #2 got = outs(); e = exp_q.pop_front(); total++;
    if (got !== e) begin bad++; $display("FAIL rst_stall_pre got=%h exp=%h", got, e); end
    exp_q.push_back(ex(0,0,0,0,0,0));
    #1 rst_n = 1'b0;
    #1 got = outs(); e = exp_q.pop_front(); total++;
    if (got !== e) begin bad++; $display("FAIL rst_stall_drop got=%h exp=%h", got, e); end
    next_cycle();
    rst_n = 1'b1;
    p = '{lw1, addu2, addu2};
    v = '{ex(0,0,0,0,0,0), ex(1,0,0,0,0,0), ex(0,0,0,0,0,0)};
    for (int k = 0; k < 3; k++) begin
      drive(p[k], v[k]);
      #2 got = outs(); e = exp_q.pop_front(); total++;
      if (got !== e) begin bad++; $display("FAIL rst_restart[%0d] got=%h exp=%h", k, got, e); end
      next_cycle();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    nop   = '0;
    lw1   = mk(29, 1, 1, 2, 0, 3);
    addu2 = mk(1, 3, 2, 2, 2, 2);
    beq1  = mk(1, 0, 0, 1, 1, 0);
    addu4 = mk(5, 6, 4, 2, 2, 2);
    beq44 = mk(4, 4, 0, 1, 1, 0);
    jal31 = mk(0, 0, 31, 0, 0, 0);
    jr31  = mk(31, 0, 0, 1, 0, 0);
    lui5  = mk(0, 5, 5, 0, 0, 1);
    sw5   = mk(0, 5, 0, 2, 3, 0);
    addu0 = mk(1, 2, 0, 2, 2, 2);
    beq00 = mk(0, 0, 0, 1, 1, 0);
    lui6  = mk(0, 6, 6, 0, 0, 1);
    beq6  = mk(6, 0, 0, 1, 1, 0);
    lw7   = mk(29, 7, 7, 2, 0, 3);
    lui7  = mk(0, 7, 7, 0, 0, 1);
    beq7  = mk(7, 0, 0, 1, 1, 0);
    set_d(nop);
    @(negedge clk);
    test_reset();
    test_lw_use();
    test_lw_branch();
    test_alu_branch();
    test_no_stall_fwd();
    test_zero_and_priority();
    test_nearest_only();
    test_reset_mid_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
